debug_secret_gate: RTL and testbench
====================================

// Module: debug_secret_gate
// PURPOSE
//  Parametrised gate between an on-chip key store and the debug port.
//  Holds NUM_SLOTS write-once secrets. Debug reads of slots 1..NUM_SLOTS-1 are
//  allowed only after token authentication against slot 0, and only for a
//  bounded window. Failed attempts are counted and end in permanent lockout.
//  Slot 0, the unlock key, is never readable. Sits between the key provisioning
//  path and the debug/JTAG register bridge.
// PARAMETERS
//  DATA_W        32   width of each key slot, auth token and read data
//  NUM_SLOTS     4    number of key slots (>=2); slot 0 is the unlock key
//  SLOT_W        2    slot index width, $clog2(NUM_SLOTS)
//  MAX_FAILS     3    failed auth attempts before LOCKOUT (>=1)
//  UNLOCK_CYCLES 256  length of the unlock window in clk cycles (>=2)
// PORTS
//  clk             in   1       single clock, all logic posedge
//  rst             in   1       synchronous, active-high reset
//  lc_prod         in   1       1 = production lifecycle; debug fully disabled
//  key_wr_valid    in   1       key provisioning write strobe
//  key_wr_slot     in   SLOT_W  slot being written
//  key_wr_data     in   DATA_W  key value
//  auth_valid      in   1       auth attempt strobe, accepted only when auth_ready
//  auth_token      in   DATA_W  token compared with slot 0
//  auth_ready      out  1       1 in LOCKED with slot 0 loaded and lc_prod=0
//  auth_done       out  1       1-cycle pulse when a check completes
//  auth_pass       out  1       qualifies auth_done; 1 = token matched
//  dbg_rd_valid    in   1       debug read request strobe
//  dbg_rd_slot     in   SLOT_W  slot to read
//  dbg_rd_rvalid   out  1       1-cycle pulse, one cycle after every dbg_rd_valid
//  dbg_rd_data     out  DATA_W  key data when granted, else all zeros
//  dbg_rd_err      out  1       qualifies dbg_rd_rvalid; 1 = denied
//  dbg_state       out  2       00 LOCKED, 01 CHECK, 10 UNLOCKED, 11 LOCKOUT
// BEHAVIOUR
//  Reset: FSM to LOCKED; slots and written flags cleared; fail_cnt=0; window
//   counter=0; every output 0. dbg_rd_data is never high-Z and never reflects
//   a key outside a granted read cycle.
//  Key store: key_wr_valid writes a slot only in LOCKED, and only if that slot
//   is unwritten. Otherwise the write is ignored. Slots are write-once until rst.
//  FSM transitions:
//   LOCKED: auth_valid && auth_ready registers the token -> CHECK.
//   CHECK: one cycle; compares the token with slot 0 and pulses auth_done.
//    Match -> UNLOCKED, auth_pass=1, fail_cnt=0, window=UNLOCK_CYCLES.
//    Mismatch -> fail_cnt+1; if the new count == MAX_FAILS go to LOCKOUT,
//    else LOCKED.
//   UNLOCKED: window decrements every cycle; at 1 -> LOCKED on the next edge,
//    giving exactly UNLOCK_CYCLES cycles in UNLOCKED. auth_valid is ignored here.
//   LOCKOUT: absorbing; only rst exits. auth_ready=0.
//   lc_prod=1 in any state: the next state is LOCKED (LOCKOUT stays LOCKOUT),
//    the window clears, and auth_ready=0.
//  Debug read: latency 1. Sampled at cycle N; rvalid, data and err are valid
//   at N+1.
//   Grant iff the state was UNLOCKED at N, slot!=0, slot<NUM_SLOTS and the slot
//   is written. On grant, data = key and err=0; else data=0 and err=1.
//   A read sampled in the last UNLOCKED cycle is still granted. A read sampled
//   in the following cycle is denied.
//  fail_cnt is $clog2(MAX_FAILS+1) bits and never wraps.
//  auth_valid while not ready: dropped, no auth_done, no fail counted.
//  rst mid-CHECK or mid-window: immediate return to the reset state; no
//   auth_done is emitted.
// TESTING
//  T1: write slot0=0xA5A5_0001 and slot1=0x1234_5678; auth 0xA5A5_0001 ->
//   auth_done, auth_pass=1, UNLOCKED; read slot1 -> 0x1234_5678, err=0.
//  T2: read slot1 while LOCKED, and read slot0 while UNLOCKED -> data=0,
//   err=1 in both cases.
//  T3: UNLOCK_CYCLES=8; auth ok, then read at window cycles 8 and 9 ->
//   granted then denied; dbg_state returns to 00.
//  T4: three wrong tokens -> auth_pass=0 each time, then LOCKOUT; a correct
//   token is ignored (auth_ready=0) until rst.
//  T5: while UNLOCKED, raise lc_prod -> LOCKED next cycle; reads are denied;
//   auth_ready=0.
//  T6: rewrite slot1 with 0xFFFF_FFFF -> the value is unchanged; assert rst
//   in CHECK -> no auth_done and all slots read back 0.

Source files
------------

// File: rtl/debug_secret_gate.sv
// debug_secret_gate
//   Gate between the on-chip key store and the debug register bridge.
//   Holds NUM_SLOTS write-once secrets. Slot 0 is the unlock key and can never
//   be read. Slots 1..NUM_SLOTS-1 become readable only for an UNLOCK_CYCLES
//   window after a token matching slot 0 is presented. MAX_FAILS wrong tokens
//   lock the gate out until rst. lc_prod=1 forces the gate closed.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   lc_prod                       production lifecycle, disables debug
//   key_wr_valid/slot/data        write-once key provisioning
//   auth_valid/token, auth_ready  authentication attempt handshake
//   auth_done, auth_pass          one-cycle check result
//   dbg_rd_valid/slot             debug read request
//   dbg_rd_rvalid/data/err        read response, one cycle after request
//   dbg_state                     00 LOCKED, 01 CHECK, 10 UNLOCKED, 11 LOCKOUT
module debug_secret_gate #(
  parameter int DATA_W        = 32,
  parameter int NUM_SLOTS     = 4,
  parameter int SLOT_W        = 2,
  parameter int MAX_FAILS     = 3,
  parameter int UNLOCK_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lc_prod,
  input  logic              key_wr_valid,
  input  logic [SLOT_W-1:0] key_wr_slot,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              auth_valid,
  input  logic [DATA_W-1:0] auth_token,
  output logic              auth_ready,
  output logic              auth_done,
  output logic              auth_pass,
  input  logic              dbg_rd_valid,
  input  logic [SLOT_W-1:0] dbg_rd_slot,
  output logic              dbg_rd_rvalid,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              dbg_rd_err,
  output logic [1:0]        dbg_state
);

  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int WIN_W = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [SLOT_W:0]  SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [FC_W-1:0]  LAST_FAIL  = FC_W'(MAX_FAILS - 1);
  localparam logic [FC_W-1:0]  FAIL_MAX   = FC_W'(MAX_FAILS);
  localparam logic [WIN_W-1:0] WIN_FULL   = WIN_W'(UNLOCK_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'b00,
    S_CHECK    = 2'b01,
    S_UNLOCKED = 2'b10,
    S_LOCKOUT  = 2'b11
  } state_t;

  state_t                          state, state_d;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] slots;
  logic [NUM_SLOTS-1:0]            written;
  logic [DATA_W-1:0]               token_q;
  logic [FC_W-1:0]                 fail_cnt, fail_cnt_d;
  logic [WIN_W-1:0]                window, window_d;
  logic                            done_d, pass_d;
  logic                            auth_fire;
  logic                            token_match;
  logic                            wr_slot_ok, wr_accept;
  logic                            rd_slot_ok, rd_grant;

  assign auth_ready  = (state == S_LOCKED) && written[0] && !lc_prod;
  assign auth_fire   = auth_valid && auth_ready;
  assign token_match = (token_q == slots[0]);
  assign dbg_state   = state;

  assign wr_slot_ok = ({1'b0, key_wr_slot} < SLOT_LIMIT);
  assign wr_accept  = key_wr_valid && (state == S_LOCKED) && wr_slot_ok &&
                      !written[key_wr_slot];

  // Slot 0 is excluded here, so the unlock key can never reach dbg_rd_data.
  assign rd_slot_ok = ({1'b0, dbg_rd_slot} < SLOT_LIMIT);
  assign rd_grant   = (state == S_UNLOCKED) && (dbg_rd_slot != '0) &&
                      rd_slot_ok && written[dbg_rd_slot];

  always_comb begin
    state_d    = state;
    fail_cnt_d = fail_cnt;
    window_d   = window;
    done_d     = 1'b0;
    pass_d     = 1'b0;
    if (lc_prod) begin
      // Production lifecycle aborts any check or window; lockout is kept.
      window_d = '0;
      if (state != S_LOCKOUT) state_d = S_LOCKED;
    end else begin
      case (state)
        S_LOCKED: begin
          if (auth_fire) state_d = S_CHECK;
        end
        S_CHECK: begin
          done_d = 1'b1;
          if (token_match) begin
            pass_d     = 1'b1;
            fail_cnt_d = '0;
            window_d   = WIN_FULL;
            state_d    = S_UNLOCKED;
          end else if (fail_cnt == LAST_FAIL) begin
            fail_cnt_d = FAIL_MAX;
            state_d    = S_LOCKOUT;
          end else begin
            fail_cnt_d = fail_cnt + 1'b1;
            state_d    = S_LOCKED;
          end
        end
        S_UNLOCKED: begin
          window_d = window - 1'b1;
          if (window == WIN_LAST) state_d = S_LOCKED;
        end
        S_LOCKOUT: begin
          state_d = S_LOCKOUT;
        end
        default: begin
          state_d = S_LOCKED;
        end
      endcase
    end
  end

  // auth_done/auth_pass are registered from the CHECK cycle, so a reset
  // sampled during CHECK suppresses the result pulse entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOCKED;
      slots         <= '0;
      written       <= '0;
      token_q       <= '0;
      fail_cnt      <= '0;
      window        <= '0;
      auth_done     <= 1'b0;
      auth_pass     <= 1'b0;
      dbg_rd_rvalid <= 1'b0;
      dbg_rd_data   <= '0;
      dbg_rd_err    <= 1'b0;
    end else begin
      state     <= state_d;
      fail_cnt  <= fail_cnt_d;
      window    <= window_d;
      auth_done <= done_d;
      auth_pass <= pass_d;
      if (auth_fire) token_q <= auth_token;
      if (wr_accept) begin
        slots[key_wr_slot]   <= key_wr_data;
        written[key_wr_slot] <= 1'b1;
      end
      dbg_rd_rvalid <= dbg_rd_valid;
      dbg_rd_data   <= (dbg_rd_valid && rd_grant) ? slots[dbg_rd_slot] : '0;
      dbg_rd_err    <= dbg_rd_valid && !rd_grant;
    end
  end

endmodule

// File: tb/tb_debug_secret_gate.sv
// tb_debug_secret_gate
//   Directed bench for debug_secret_gate with a short unlock window
//   (UNLOCK_CYCLES=8). A behavioural model tracks keys, remaining window
//   length, failure count and lockout, and is compared with every DUT output
//   on each falling edge; literal expectations pin key points of the scenario.
module tb_debug_secret_gate;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int MF = 3;
  localparam int UC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lc_prod = 1'b0;
  logic          key_wr_valid = 1'b0;
  logic [SW-1:0] key_wr_slot = '0;
  logic [DW-1:0] key_wr_data = '0;
  logic          auth_valid = 1'b0;
  logic [DW-1:0] auth_token = '0;
  logic          auth_ready;
  logic          auth_done;
  logic          auth_pass;
  logic          dbg_rd_valid = 1'b0;
  logic [SW-1:0] dbg_rd_slot = '0;
  logic          dbg_rd_rvalid;
  logic [DW-1:0] dbg_rd_data;
  logic          dbg_rd_err;
  logic [1:0]    dbg_state;

  debug_secret_gate #(
    .DATA_W(DW), .NUM_SLOTS(NS), .SLOT_W(SW), .MAX_FAILS(MF), .UNLOCK_CYCLES(UC)
  ) dut (
    .clk(clk), .rst(rst), .lc_prod(lc_prod),
    .key_wr_valid(key_wr_valid), .key_wr_slot(key_wr_slot), .key_wr_data(key_wr_data),
    .auth_valid(auth_valid), .auth_token(auth_token), .auth_ready(auth_ready),
    .auth_done(auth_done), .auth_pass(auth_pass),
    .dbg_rd_valid(dbg_rd_valid), .dbg_rd_slot(dbg_rd_slot),
    .dbg_rd_rvalid(dbg_rd_rvalid), .dbg_rd_data(dbg_rd_data), .dbg_rd_err(dbg_rd_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_key [NS];
  bit          m_wr  [NS];
  int          m_fails = 0;
  int          m_remaining = 0;   // cycles of access left; >0 means unlocked
  bit          m_lockout = 0;
  bit          m_checking = 0;
  logic [31:0] m_token = '0;
  bit          m_done = 0, m_pass = 0, m_rvalid = 0, m_err = 0;
  logic [31:0] m_data = '0;
  bit          m_valid = 0;

  function automatic logic [1:0] m_code();
    if (m_lockout)            return 2'd3;
    else if (m_checking)      return 2'd1;
    else if (m_remaining > 0) return 2'd2;
    else                      return 2'd0;
  endfunction

  task automatic model_step();
    logic [1:0] code;
    bit         ready, grant;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin m_key[i] = '0; m_wr[i] = 0; end
      m_fails = 0; m_remaining = 0; m_lockout = 0; m_checking = 0; m_token = '0;
      m_done = 0; m_pass = 0; m_rvalid = 0; m_err = 0; m_data = '0;
      m_valid = 1;
      return;
    end
    code  = m_code();
    ready = (code == 2'd0) && m_wr[0] && !lc_prod;
    grant = (code == 2'd2) && (dbg_rd_slot != 0) && m_wr[dbg_rd_slot];
    m_rvalid = dbg_rd_valid;
    m_data   = (dbg_rd_valid && grant) ? m_key[dbg_rd_slot] : 32'h0;
    m_err    = dbg_rd_valid && !grant;
    if (code == 2'd0 && key_wr_valid && !m_wr[key_wr_slot]) begin
      m_key[key_wr_slot] = key_wr_data;
      m_wr[key_wr_slot]  = 1;
    end
    m_done = 0; m_pass = 0;
    if (lc_prod) begin
      m_remaining = 0;
      m_checking  = 0;
    end else if (m_lockout) begin
      m_lockout = 1;
    end else if (m_checking) begin
      m_checking = 0;
      m_done     = 1;
      if (m_token == m_key[0]) begin
        m_pass = 1; m_fails = 0; m_remaining = UC;
      end else begin
        m_fails++;
        if (m_fails >= MF) m_lockout = 1;
      end
    end else if (m_remaining > 0) begin
      m_remaining--;
    end else if (auth_valid && ready) begin
      m_checking = 1;
      m_token    = auth_token;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state",      dbg_state, m_code());
      chk("auth_ready", auth_ready, (m_code() == 2'd0) && m_wr[0] && !lc_prod);
      chk("auth_done",  auth_done, m_done);
      chk("auth_pass",  auth_pass, m_pass);
      chk("rd_rvalid",  dbg_rd_rvalid, m_rvalid);
      chk("rd_data",    dbg_rd_data, m_data);
      chk("rd_err",     dbg_rd_err, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [SW-1:0] s, input logic [DW-1:0] d);
    key_wr_valid = 1'b1; key_wr_slot = s; key_wr_data = d;
    tick(1);
    key_wr_valid = 1'b0;
  endtask

  task automatic auth(input logic [DW-1:0] t);
    auth_valid = 1'b1; auth_token = t;
    tick(1);
    auth_valid = 1'b0;
  endtask

  task automatic rd(input logic [SW-1:0] s);
    dbg_rd_valid = 1'b1; dbg_rd_slot = s;
    tick(1);
    dbg_rd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("lit_reset_state", dbg_state, 2'b00);
    chk("lit_reset_ready", auth_ready, 1'b0);
    chk("lit_reset_rvalid", dbg_rd_rvalid, 1'b0);
    chk("lit_reset_data", dbg_rd_data, 32'h0);

    // T1: provision, authenticate, read slot 1
    wr_key(2'd0, 32'hA5A5_0001);
    wr_key(2'd1, 32'h1234_5678);
    chk("lit_t1_ready", auth_ready, 1'b1);
    auth(32'hA5A5_0001);
    chk("lit_t1_check", dbg_state, 2'b01);
    chk("lit_t1_nodone", auth_done, 1'b0);
    tick(1);                                  // unlocked cycle 1
    chk("lit_t1_done", auth_done, 1'b1);
    chk("lit_t1_pass", auth_pass, 1'b1);
    chk("lit_t1_unl", dbg_state, 2'b10);
    rd(2'd1);                                 // sampled cycle 1
    chk("lit_t1_rvalid", dbg_rd_rvalid, 1'b1);
    chk("lit_t1_data", dbg_rd_data, 32'h1234_5678);
    chk("lit_t1_err", dbg_rd_err, 1'b0);

    // T2: slot 0 is never readable
    rd(2'd0);                                 // sampled cycle 2
    chk("lit_t2_s0_data", dbg_rd_data, 32'h0);
    chk("lit_t2_s0_err", dbg_rd_err, 1'b1);

    // T3: last window cycle granted, following cycle denied
    tick(5);                                  // now in cycle 8
    chk("lit_t3_c8_state", dbg_state, 2'b10);
    dbg_rd_valid = 1'b1; dbg_rd_slot = 2'd1;
    tick(1);                                  // sampled cycle 8
    chk("lit_t3_c8_data", dbg_rd_data, 32'h1234_5678);
    chk("lit_t3_c8_err", dbg_rd_err, 1'b0);
    chk("lit_t3_relock", dbg_state, 2'b00);
    tick(1);                                  // sampled cycle 9 (LOCKED)
    dbg_rd_valid = 1'b0;
    chk("lit_t3_c9_data", dbg_rd_data, 32'h0);
    chk("lit_t3_c9_err", dbg_rd_err, 1'b1);

    // T6a: write-once slot
    wr_key(2'd1, 32'hFFFF_FFFF);

    // T5: lc_prod closes an open window
    auth(32'hA5A5_0001);
    tick(1);
    chk("lit_t5_pass", auth_pass, 1'b1);
    rd(2'd1);
    chk("lit_t6_unchanged", dbg_rd_data, 32'h1234_5678);
    lc_prod = 1'b1;
    tick(1);
    chk("lit_t5_state", dbg_state, 2'b00);
    chk("lit_t5_ready", auth_ready, 1'b0);
    rd(2'd1);
    chk("lit_t5_rd_err", dbg_rd_err, 1'b1);
    auth(32'hA5A5_0001);
    chk("lit_t5_noauth", dbg_state, 2'b00);
    tick(1);
    chk("lit_t5_nodone", auth_done, 1'b0);
    lc_prod = 1'b0;
    tick(1);

    // T4: three wrong tokens, then lockout
    for (int i = 0; i < MF; i++) begin
      auth(32'hDEAD_0000 + 32'(i));
      tick(1);
      chk("lit_t4_done", auth_done, 1'b1);
      chk("lit_t4_pass", auth_pass, 1'b0);
    end
    chk("lit_t4_lockout", dbg_state, 2'b11);
    chk("lit_t4_ready", auth_ready, 1'b0);
    auth(32'hA5A5_0001);
    tick(1);
    chk("lit_t4_ignored", auth_done, 1'b0);
    chk("lit_t4_still", dbg_state, 2'b11);

    // T6b: reset exits lockout; reset during CHECK drops the result
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_t6_rst_state", dbg_state, 2'b00);
    wr_key(2'd0, 32'hA5A5_0001);
    wr_key(2'd1, 32'h55AA_55AA);
    auth(32'hA5A5_0001);
    chk("lit_t6_check", dbg_state, 2'b01);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_t6_nodone", auth_done, 1'b0);
    chk("lit_t6_locked", dbg_state, 2'b00);
    // slot 0 accepts a new key only if reset really cleared it
    wr_key(2'd0, 32'h0BAD_F00D);
    auth(32'h0BAD_F00D);
    tick(1);
    chk("lit_t6_newkey", auth_pass, 1'b1);
    for (int s = 1; s < NS; s++) begin
      rd(SW'(s));
      chk("lit_t6_cleared_data", dbg_rd_data, 32'h0);
      chk("lit_t6_cleared_err", dbg_rd_err, 1'b1);
    end
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
